// File: rtl/sobel_uart_pkg.sv
// Shared definitions for the Sobel frame sender: header sync bytes, header
// length, the sender state encoding and a header byte selector.
package sobel_uart_pkg;

    localparam logic [7:0] HDR_SYNC0 = 8'hA5;
    localparam logic [7:0] HDR_SYNC1 = 8'h5A;
    localparam int         HDR_LEN   = 8;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        HDR      = 3'd1,
        FETCH    = 3'd2,
        LOAD     = 3'd3,
        SEND     = 3'd4,
        CKSUM    = 3'd5,
        DONE     = 3'd6,
        WAIT_CLR = 3'd7
    } state_t;

    // Header byte at position idx: sync pair, big-endian frame id, big-endian length.
    function automatic logic [7:0] hdr_byte(input logic [2:0]  idx,
                                            input logic [31:0] frame_id,
                                            input logic [15:0] len);
        logic [7:0] b;
        case (idx)
            3'd0:    b = HDR_SYNC0;
            3'd1:    b = HDR_SYNC1;
            3'd2:    b = frame_id[31:24];
            3'd3:    b = frame_id[23:16];
            3'd4:    b = frame_id[15:8];
            3'd5:    b = frame_id[7:0];
            3'd6:    b = len[15:8];
            default: b = len[7:0];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop level synchronizer for a single asynchronous control bit.
module sync_2ff (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // Shift the asynchronous level through two flops to settle metastability.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/sobel_uart_frame_sender.sv
// Streams one packed 1bpp Sobel frame from BRAM to a UART transmitter as
// an 8-byte header followed by PAYLOAD_LEN payload bytes. Defining
// SOBEL_TX_CHECKSUM_EN appends an XOR checksum byte over the payload.
module sobel_uart_frame_sender
    import sobel_uart_pkg::*;
#(
    parameter int PAYLOAD_LEN = 38400,
    parameter int ADDR_WIDTH  = 16
) (
    input  logic                  clk_uart,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  frame_ready_vga,
    input  logic [31:0]           frame_id_vga,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [7:0]            rd_data,
    output logic [7:0]            tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    output logic                  consume_toggle_uart,
    output logic                  busy,
    output logic [15:0]           frames_sent
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(PAYLOAD_LEN - 1);
    localparam logic [15:0]           LEN16     = 16'(PAYLOAD_LEN);
    localparam logic [2:0]            HDR_LAST  = 3'(HDR_LEN - 1);

    logic                  rdy_s;
    state_t                state_q;
    logic [2:0]            hdr_idx_q;
    logic [2:0]            hdr_idx_d;
    logic [31:0]           frame_id_q;
    logic [ADDR_WIDTH-1:0] rd_addr_q;
    logic [ADDR_WIDTH-1:0] rd_addr_d;
    logic [7:0]            tx_data_q;
    logic                  tx_valid_q;
    logic                  toggle_q;
    logic                  busy_q;
    logic [15:0]           frames_sent_q;
`ifdef SOBEL_TX_CHECKSUM_EN
    logic [7:0]            checksum_q;
`endif

    sync_2ff u_sync_rdy (
        .clk_i   (clk_uart),
        .rst_n_i (rst_n),
        .d_i     (frame_ready_vga),
        .q_o     (rdy_s)
    );

    // Next header index and next payload address.
    always_comb begin
        hdr_idx_d = hdr_idx_q + 3'd1;
        rd_addr_d = rd_addr_q + 1'b1;
    end

    // Frame sequencer; all outputs are registered here.
    always_ff @(posedge clk_uart or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            hdr_idx_q     <= 3'd0;
            frame_id_q    <= 32'd0;
            rd_addr_q     <= '0;
            tx_data_q     <= 8'd0;
            tx_valid_q    <= 1'b0;
            toggle_q      <= 1'b0;
            busy_q        <= 1'b0;
            frames_sent_q <= 16'd0;
`ifdef SOBEL_TX_CHECKSUM_EN
            checksum_q    <= 8'd0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    tx_valid_q <= 1'b0;
                    if (rdy_s && enable) begin
                        state_q    <= HDR;
                        frame_id_q <= frame_id_vga;
                        hdr_idx_q  <= 3'd0;
                        rd_addr_q  <= '0;
                        busy_q     <= 1'b1;
                    end
                end
                HDR: begin
`ifdef SOBEL_TX_CHECKSUM_EN
                    checksum_q <= 8'd0;
`endif
                    if (!tx_valid_q) begin
                        tx_data_q  <= hdr_byte(hdr_idx_q, frame_id_q, LEN16);
                        tx_valid_q <= 1'b1;
                    end else if (tx_ready) begin
                        if (hdr_idx_q == HDR_LAST) begin
                            tx_valid_q <= 1'b0;
                            state_q    <= FETCH;
                        end else begin
                            // Back-to-back header bytes: load the next one on acceptance.
                            hdr_idx_q <= hdr_idx_d;
                            tx_data_q <= hdr_byte(hdr_idx_d, frame_id_q, LEN16);
                        end
                    end
                end
                FETCH: begin
                    tx_valid_q <= 1'b0;
                    state_q    <= LOAD;
                end
                LOAD: begin
                    tx_data_q  <= rd_data;
                    tx_valid_q <= 1'b1;
                    state_q    <= SEND;
`ifdef SOBEL_TX_CHECKSUM_EN
                    checksum_q <= checksum_q ^ rd_data;
`endif
                end
                SEND: begin
                    if (tx_ready) begin
                        tx_valid_q <= 1'b0;
                        if (rd_addr_q == LAST_ADDR) begin
`ifdef SOBEL_TX_CHECKSUM_EN
                            state_q <= CKSUM;
`else
                            state_q <= DONE;
`endif
                        end else begin
                            rd_addr_q <= rd_addr_d;
                            state_q   <= FETCH;
                        end
                    end
                end
`ifdef SOBEL_TX_CHECKSUM_EN
                CKSUM: begin
                    if (!tx_valid_q) begin
                        tx_data_q  <= checksum_q;
                        tx_valid_q <= 1'b1;
                    end else if (tx_ready) begin
                        tx_valid_q <= 1'b0;
                        state_q    <= DONE;
                    end
                end
`endif
                DONE: begin
                    tx_valid_q    <= 1'b0;
                    toggle_q      <= ~toggle_q;
                    frames_sent_q <= frames_sent_q + 16'd1;
                    state_q       <= WAIT_CLR;
                end
                WAIT_CLR: begin
                    // Hold off until the producer clears its flag so a frame is never resent.
                    tx_valid_q <= 1'b0;
                    if (!rdy_s) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    tx_valid_q <= 1'b0;
                    busy_q     <= 1'b0;
                    state_q    <= IDLE;
                end
            endcase
        end
    end

    assign rd_addr             = rd_addr_q;
    assign tx_data             = tx_data_q;
    assign tx_valid            = tx_valid_q;
    assign consume_toggle_uart = toggle_q;
    assign busy                = busy_q;
    assign frames_sent         = frames_sent_q;

endmodule

// File: tb/tb_sobel_uart_frame_sender.sv
// Directed bench for sobel_uart_frame_sender with a 16-byte payload.
// Honours SOBEL_TX_CHECKSUM_EN when deciding whether a trailing byte is expected.
module tb_sobel_uart_frame_sender;

    localparam int PLEN = 16;
    localparam int AW   = 16;

    logic          clk_uart = 1'b0;
    logic          rst_n;
    logic          enable;
    logic          frame_ready_vga;
    logic [31:0]   frame_id_vga;
    logic [AW-1:0] rd_addr;
    logic [7:0]    rd_data;
    logic [7:0]    tx_data;
    logic          tx_valid;
    logic          tx_ready;
    logic          consume_toggle_uart;
    logic          busy;
    logic [15:0]   frames_sent;

    int errors = 0;
    int checks = 0;

    logic [7:0] ram [PLEN];
    logic [7:0] rx_q [$];
    logic [7:0] exp_q [$];
    logic [15:0] exp_fs;
    logic        exp_tog;

    typedef struct {
        logic [31:0] id;
        int          pattern;
        int          stall_at;
        int          stall_len;
        int          drop_en_at;
        logic [7:0]  cksum;
    } vec_t;

    vec_t vecs [4];

    sobel_uart_frame_sender #(
        .PAYLOAD_LEN (PLEN),
        .ADDR_WIDTH  (AW)
    ) dut (
        .clk_uart            (clk_uart),
        .rst_n               (rst_n),
        .enable              (enable),
        .frame_ready_vga     (frame_ready_vga),
        .frame_id_vga        (frame_id_vga),
        .rd_addr             (rd_addr),
        .rd_data             (rd_data),
        .tx_data             (tx_data),
        .tx_valid            (tx_valid),
        .tx_ready            (tx_ready),
        .consume_toggle_uart (consume_toggle_uart),
        .busy                (busy),
        .frames_sent         (frames_sent)
    );

    always #5 clk_uart = ~clk_uart;

    // Registered-read BRAM model
    always @(posedge clk_uart)
        rd_data <= (rd_addr < AW'(PLEN)) ? ram[rd_addr[3:0]] : 8'h00;

    // Capture every accepted byte
    always @(posedge clk_uart)
        if (rst_n && tx_valid && tx_ready) rx_q.push_back(tx_data);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fill_ram(input int pattern);
        for (int i = 0; i < PLEN; i++)
            ram[i] = (pattern == 0) ? 8'(i + 1) : 8'(i * 8'h11);
    endtask

    task automatic build_expected(input logic [31:0] id, input logic [7:0] cksum);
        exp_q.delete();
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'h5A);
        exp_q.push_back(id[31:24]);
        exp_q.push_back(id[23:16]);
        exp_q.push_back(id[15:8]);
        exp_q.push_back(id[7:0]);
        exp_q.push_back(8'h00);
        exp_q.push_back(8'h10);
        for (int i = 0; i < PLEN; i++) exp_q.push_back(ram[i]);
`ifdef SOBEL_TX_CHECKSUM_EN
        exp_q.push_back(cksum);
`else
        if (cksum != cksum) exp_q.push_back(cksum);
`endif
    endtask

    task automatic compare_stream(input string name);
        int n;
        check({name, " byte count"}, rx_q.size(), exp_q.size());
        n = (rx_q.size() < exp_q.size()) ? rx_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            check($sformatf("%s byte %0d", name, i), rx_q[i], exp_q[i]);
        $display("stream %s: %0d bytes received, %0d expected", name, rx_q.size(), exp_q.size());
    endtask

    // Wait (bounded) for frames_sent to move away from prev
    task automatic wait_frame_done(input string name, input logic [15:0] prev, input vec_t v);
        int  cyc;
        bit  stalled;
        logic [7:0] held;
        cyc = 0;
        stalled = 0;
        while (frames_sent == prev && cyc < 2000) begin
            @(negedge clk_uart);
            cyc++;
            if (v.drop_en_at >= 0 && rx_q.size() == 8 + v.drop_en_at) enable = 1'b0;
            if (!stalled && v.stall_at >= 0 && tx_valid && rx_q.size() == 8 + v.stall_at) begin
                stalled = 1;
                held = tx_data;
                check({name, " stalled byte"}, held, ram[v.stall_at]);
                tx_ready = 1'b0;
                for (int s = 0; s < v.stall_len; s++) begin
                    @(negedge clk_uart);
                    check($sformatf("%s hold valid %0d", name, s), tx_valid, 1'b1);
                    check($sformatf("%s hold data %0d", name, s), tx_data, held);
                end
                tx_ready = 1'b1;
            end
        end
        check({name, " frame timeout"}, (cyc >= 2000) ? 1 : 0, 0);
    endtask

    task automatic run_frame(input string name, input vec_t v);
        int lat;
        logic [15:0] prev;
        fill_ram(v.pattern);
        build_expected(v.id, v.cksum);
        rx_q.delete();
        prev = frames_sent;
        frame_id_vga = v.id;
        enable = 1'b1;
        frame_ready_vga = 1'b1;
        lat = 0;
        while (!tx_valid && lat < 20) begin
            @(negedge clk_uart);
            lat++;
        end
        check({name, " start latency"}, lat, 4);
        wait_frame_done(name, prev, v);
        exp_fs = exp_fs + 16'd1;
        exp_tog = ~exp_tog;
        check({name, " frames_sent"}, frames_sent, exp_fs);
        check({name, " consume toggle"}, consume_toggle_uart, exp_tog);
        compare_stream(name);
        // Flag still high: sender must park without resending
        repeat (20) @(negedge clk_uart);
        check({name, " no resend"}, rx_q.size(), exp_q.size());
        check({name, " busy in wait"}, busy, 1'b1);
        frame_ready_vga = 1'b0;
        repeat (5) @(negedge clk_uart);
        check({name, " busy cleared"}, busy, 1'b0);
        enable = 1'b1;
    endtask

    initial begin
        vec_t r;
        int   cyc;
        vecs[0] = '{id: 32'h0000_0007, pattern: 0, stall_at: -1, stall_len: 0, drop_en_at: -1, cksum: 8'h10};
        vecs[1] = '{id: 32'hDEAD_BEEF, pattern: 1, stall_at: 3,  stall_len: 5, drop_en_at: -1, cksum: 8'h00};
        vecs[2] = '{id: 32'h1234_5678, pattern: 0, stall_at: -1, stall_len: 0, drop_en_at: 5,  cksum: 8'h10};
        vecs[3] = '{id: 32'hFFFF_0001, pattern: 1, stall_at: 15, stall_len: 2, drop_en_at: -1, cksum: 8'h00};

        rst_n = 1'b0;
        enable = 1'b0;
        frame_ready_vga = 1'b0;
        frame_id_vga = 32'd0;
        tx_ready = 1'b1;
        exp_fs = 16'd0;
        exp_tog = 1'b0;
        fill_ram(0);
        repeat (3) @(negedge clk_uart);
        check("reset tx_valid", tx_valid, 1'b0);
        check("reset busy", busy, 1'b0);
        check("reset frames_sent", frames_sent, 16'd0);
        check("reset toggle", consume_toggle_uart, 1'b0);
        check("reset rd_addr", rd_addr, 16'd0);
        check("reset tx_data", tx_data, 8'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk_uart);

        // Flag high but enable low: must stay idle
        frame_ready_vga = 1'b1;
        frame_id_vga = 32'h0000_0099;
        repeat (20) @(negedge clk_uart);
        check("disabled busy", busy, 1'b0);
        check("disabled no bytes", rx_q.size(), 0);
        frame_ready_vga = 1'b0;
        repeat (5) @(negedge clk_uart);

        for (int i = 0; i < 4; i++)
            run_frame($sformatf("vec%0d", i), vecs[i]);

        // Reset pulsed while payload byte 8 is presented, then full resend
        r = '{id: 32'hCAFE_0008, pattern: 0, stall_at: -1, stall_len: 0, drop_en_at: -1, cksum: 8'h10};
        fill_ram(0);
        build_expected(r.id, r.cksum);
        rx_q.delete();
        frame_id_vga = r.id;
        enable = 1'b1;
        frame_ready_vga = 1'b1;
        cyc = 0;
        while (!(tx_valid && rx_q.size() == 16) && cyc < 500) begin
            @(negedge clk_uart);
            cyc++;
        end
        check("rst reach byte 8", (cyc >= 500) ? 1 : 0, 0);
        rst_n = 1'b0;
        #1;
        check("midrst tx_valid", tx_valid, 1'b0);
        check("midrst busy", busy, 1'b0);
        check("midrst rd_addr", rd_addr, 16'd0);
        check("midrst tx_data", tx_data, 8'd0);
        check("midrst toggle", consume_toggle_uart, 1'b0);
        check("midrst frames_sent", frames_sent, 16'd0);
        @(negedge clk_uart);
        rst_n = 1'b1;
        rx_q.delete();
        exp_fs = 16'd0;
        exp_tog = 1'b0;
        wait_frame_done("resend", 16'd0, r);
        exp_fs = 16'd1;
        exp_tog = 1'b1;
        check("resend frames_sent", frames_sent, exp_fs);
        check("resend toggle", consume_toggle_uart, exp_tog);
        check("resend first byte", (rx_q.size() > 0) ? 32'(rx_q[0]) : 32'hFFFF_FFFF, 32'h0000_00A5);
        compare_stream("resend");
        frame_ready_vga = 1'b0;
        repeat (5) @(negedge clk_uart);
        check("resend busy cleared", busy, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sobel_uart_frame_sender.md
SOBEL_UART_FRAME_SENDER -- requirements
Module: sobel_uart_frame_sender

Interface
REQ-001 SHALL have parameter PAYLOAD_LEN, default 38400, meaning the packed 1bpp payload bytes per frame.
REQ-002 SHALL have parameter ADDR_WIDTH, default 16, meaning the BRAM read address width.
REQ-003 SHALL have port clk_uart, input, 1, the single clock of the block.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port enable, input, 1, permission to start a new frame.
REQ-006 SHALL have port frame_ready_vga, input, 1, buffer-FULL flag from the VGA domain (asynchronous).
REQ-007 SHALL have port frame_id_vga, input, 32, frame number; stable while frame_ready_vga is high.
REQ-008 SHALL have port rd_addr, output, ADDR_WIDTH, BRAM read address.
REQ-009 SHALL have port rd_data, input, 8, BRAM data, valid one clk_uart cycle after rd_addr.
REQ-010 SHALL have port tx_data, output, 8, byte to the UART transmitter.
REQ-011 SHALL have port tx_valid, output, 1, tx_data is valid.
REQ-012 SHALL have port tx_ready, input, 1, the transmitter accepts the byte this cycle.
REQ-013 SHALL have port consume_toggle_uart, output, 1, toggles once per fully sent frame.
REQ-014 SHALL have port busy, output, 1, high in every state except IDLE.
REQ-015 SHALL have port frames_sent, output, 16, count of completed frames (wraps 0xFFFF->0).

Function
REQ-016 SHALL pass frame_ready_vga through a 2-FF synchronizer; rdy_s is the synchronized level.
REQ-017 SHALL use states IDLE, HDR, FETCH, LOAD, SEND, CKSUM, DONE, WAIT_CLR.
REQ-018 SHALL go IDLE->HDR when rdy_s=1 and enable=1, capturing frame_id_vga into an internal register that cycle.
REQ-019 SHALL send an 8-byte header in HDR: 0xA5, 0x5A, frame_id[31:24], [23:16], [15:8], [7:0], PAYLOAD_LEN[15:8], PAYLOAD_LEN[7:0].
REQ-020 SHALL transfer a byte only on a cycle with tx_valid=1 and tx_ready=1, and SHALL hold tx_data stable while tx_valid=1 and tx_ready=0.
REQ-021 SHALL, per payload byte, drive rd_addr in FETCH, register rd_data in LOAD, and present it in SEND until accepted; rd_addr increments from 0 to PAYLOAD_LEN-1.
REQ-022 SHALL keep tx_valid=0 in FETCH, LOAD, DONE, WAIT_CLR and IDLE.
REQ-023 SHALL go SEND->FETCH after acceptance while addr<PAYLOAD_LEN-1; after acceptance of byte PAYLOAD_LEN-1 go to CKSUM (macro on) or DONE (macro off).
REQ-024 SHALL in DONE invert consume_toggle_uart for exactly one edge, increment frames_sent, and go to WAIT_CLR.
REQ-025 SHALL in WAIT_CLR wait for rdy_s=0 before entering IDLE, so one frame is never sent twice.
REQ-026 SHALL finish any frame in progress when enable falls mid-frame; enable gates only the IDLE->HDR transition.
REQ-027 SHALL ignore frame_ready_vga changes in every state except IDLE and WAIT_CLR.
REQ-028 SHALL give a minimum latency of 2 cycles from rdy_s rising in IDLE to tx_valid=1 on header byte 0.

Reset
REQ-029 SHALL on rst_n=0 asynchronously force state=IDLE, rd_addr=0, tx_data=0, tx_valid=0, consume_toggle_uart=0, busy=0, frames_sent=0, synchronizer flops=0, checksum=0.
REQ-030 SHALL, after reset asserted mid-frame, restart from IDLE with no consume toggle; a still-high rdy_s starts a full resend.

Configuration
REQ-031 SHALL, with macro SOBEL_TX_CHECKSUM_EN defined, XOR all payload bytes into an 8-bit checksum (cleared in HDR) and send it as one trailing byte in CKSUM.
REQ-032 SHALL, without SOBEL_TX_CHECKSUM_EN, omit the CKSUM state and the checksum register; the packet ends after the last payload byte.

Structure
REQ-033 SHALL take the header constants 0xA5/0x5A, the header length 8, and the state encoding from the shared package sobel_uart_pkg.
REQ-034 SHALL implement the synchronizer as sub-module sync_2ff (1-bit, asynchronous active-low reset).

Verification
REQ-035 SHALL cover: PAYLOAD_LEN=16, frame_id=0x00000007, tx_ready always 1 -> bytes A5 5A 00 00 00 07 00 10 followed by RAM[0..15]; one consume toggle; frames_sent=1.
REQ-036 SHALL cover: tx_ready low for 5 cycles during payload byte 3 -> tx_data held constant, with no byte duplicated or skipped.
REQ-037 SHALL cover: frame_ready_vga held high after DONE -> no second header until it goes low, then high again.
REQ-038 SHALL cover: macro on, RAM = 0x01..0x10 -> trailing byte 0x10; macro off -> no trailing byte.
REQ-039 SHALL cover: rst_n pulsed during payload byte 8 -> all outputs at reset values; a resend starts with header byte 0xA5.
REQ-040 SHALL cover: enable=0 while frame_ready_vga=1 -> busy stays 0; enable dropped mid-payload -> the frame completes.
